wb_source_select: RTL and testbench

- Registered, parametrised write-back source selector for the multicycle datapath.
- Chooses one of NUM_SRC register-file write sources (ALU flag, shifter, HI/LO, MDR, ALUOut, …) and applies load-lane extraction and extension.
- Holds the result in a one-entry output register under a valid/ready handshake, so the register file write can be decoupled from the cycle the source is selected.
- Unpopulated selector codes return a fixed sentinel value.

---
 rtl/wb_source_select.sv | 98 +++++++++
 tb/tb_wb_source_select.sv | 133 +++++++++++++
 2 files changed

// File: rtl/wb_source_select.sv
// wb_source_select: registered write-back source mux with load-lane extraction/extension and a valid/ready output stage
module wb_source_select #(
  parameter int                 WIDTH         = 32,
  parameter int                 NUM_SRC       = 8,
  parameter int                 SEL_W         = 3,
  parameter logic [NUM_SRC-1:0] SRC_MASK      = 8'b1110_1111,
  parameter int                 DEFAULT_VALUE = 227
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         seletor,
  input  logic [2:0]               ext_mode,
  input  logic [1:0]               lane,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         wb_data,
  output logic [SEL_W-1:0]         wb_src,
  output logic                     default_hit
);
  localparam int NCODE = 2**SEL_W;
  localparam int EW = WIDTH > 32 ? WIDTH : 32;
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_VALUE);
  logic [WIDTH-1:0] w_src [NCODE];
  logic [NCODE-1:0] w_pop;
  logic [7:0]       w_bytes [4];
  logic [15:0]      w_halves [2];
  logic [WIDTH-1:0] w_raw;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [EW-1:0]    w_ext;
  logic             w_hit;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_src;
  logic             r_hit;
  // Codes beyond NUM_SRC or masked off collapse onto the sentinel
  for (genvar i = 0; i < NCODE; i++) begin : g_src
    if (i < NUM_SRC) begin : g_in
      if (SRC_MASK[i]) begin : g_pop
        assign w_src[i] = src_data[i*WIDTH +: WIDTH];
        assign w_pop[i] = 1'b1;
      end else begin : g_unpop
        assign w_src[i] = DEF;
        assign w_pop[i] = 1'b0;
      end
    end else begin : g_oor
      assign w_src[i] = DEF;
      assign w_pop[i] = 1'b0;
    end
  end
  assign w_raw = w_src[seletor];
  assign w_hit = !w_pop[seletor];
  // Lanes that do not fit inside a narrow WIDTH read as zero
  for (genvar b = 0; b < 4; b++) begin : g_byte
    if ((b + 1) * 8 <= WIDTH) begin : g_fit
      assign w_bytes[b] = w_raw[b*8 +: 8];
    end else begin : g_nofit
      assign w_bytes[b] = 8'h00;
    end
  end
  for (genvar h = 0; h < 2; h++) begin : g_half
    if ((h + 1) * 16 <= WIDTH) begin : g_fit
      assign w_halves[h] = w_raw[h*16 +: 16];
    end else begin : g_nofit
      assign w_halves[h] = 16'h0000;
    end
  end
  assign w_byte = w_bytes[lane];
  assign w_half = w_halves[lane[1]];
  always_comb
    w_ext = ext_mode == 3'd1 ? EW'(w_byte) :
            ext_mode == 3'd2 ? {{(EW-8){w_byte[7]}}, w_byte} :
            ext_mode == 3'd3 ? EW'(w_half) :
            ext_mode == 3'd4 ? {{(EW-16){w_half[15]}}, w_half} :
            EW'(w_raw);
  assign in_ready = !r_valid || out_ready;
  always_ff @(posedge clk)
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_hit   <= 1'b0;
    end else if (in_valid && in_ready) begin
      r_valid <= 1'b1;
      r_data  <= w_ext[WIDTH-1:0];
      r_src   <= seletor;
      r_hit   <= w_hit;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  assign out_valid   = r_valid;
  assign wb_data     = r_data;
  assign wb_src      = r_src;
  assign default_hit = r_hit;
endmodule

// File: tb/tb_wb_source_select.sv
// tb_wb_source_select: directed checks of selection, extension, sentinel and handshake behaviour
module tb_wb_source_select;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] src_data;
  logic [2:0]   seletor;
  logic [2:0]   ext_mode;
  logic [1:0]   lane;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  wb_data;
  logic [2:0]   wb_src;
  logic         default_hit;
  int checks = 0;
  int errors = 0;

  wb_source_select dut (
    .clk(clk), .reset_n(reset_n), .src_data(src_data), .seletor(seletor),
    .ext_mode(ext_mode), .lane(lane), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data),
    .wb_src(wb_src), .default_hit(default_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [31:0] v);
    src_data[i*32 +: 32] = v;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; src_data = '1;
    seletor = 3'd6; ext_mode = 3'd0; lane = 2'd0;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", wb_data, 32'd0);
    check("rst_src", 32'(wb_src), 32'd0);
    check("rst_hit", 32'(default_hit), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    reset_n = 1'b1; out_ready = 1'b1;
    set_src(6, 32'hDEAD_BEEF);
    tick();
    check("word_data", wb_data, 32'hDEAD_BEEF);
    check("word_src", 32'(wb_src), 32'd6);
    check("word_valid", 32'(out_valid), 32'd1);
    check("word_hit", 32'(default_hit), 32'd0);

    src_data = '1; seletor = 3'd4;
    tick();
    check("unpop_data", wb_data, 32'd227);
    check("unpop_hit", 32'(default_hit), 32'd1);
    ext_mode = 3'd2; lane = 2'd0;
    tick();
    check("unpop_sext", wb_data, 32'hFFFF_FFE3);

    set_src(5, 32'h80F1_7F82); seletor = 3'd5;
    ext_mode = 3'd2; lane = 2'd3; tick();
    check("bsext_l3", wb_data, 32'hFFFF_FF80);
    check("bsext_hit", 32'(default_hit), 32'd0);
    ext_mode = 3'd1; lane = 2'd0; tick();
    check("bzext_l0", wb_data, 32'h0000_0082);
    ext_mode = 3'd4; lane = 2'd2; tick();
    check("hsext_l2", wb_data, 32'hFFFF_80F1);
    ext_mode = 3'd3; lane = 2'd1; tick();
    check("hzext_l1", wb_data, 32'h0000_7F82);
    ext_mode = 3'd5; lane = 2'd3; tick();
    check("mode5_word", wb_data, 32'h80F1_7F82);

    ext_mode = 3'd0; lane = 2'd0;
    set_src(7, 32'h1); seletor = 3'd7;
    tick();
    check("bp_a", wb_data, 32'h1);
    out_ready = 1'b0; set_src(7, 32'h2);
    #1;
    check("bp_ready_lo", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_data", wb_data, 32'h1);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_hi", 32'(in_ready), 32'd1);
    tick();
    check("bp_b", wb_data, 32'h2);
    check("bp_b_valid", 32'(out_valid), 32'd1);

    for (int i = 0; i < 8; i++) set_src(i, 32'hA0 + 32'(i));
    for (int i = 0; i < 8; i++) begin
      seletor = 3'(i);
      tick();
      check("b2b_data", wb_data, i == 4 ? 32'd227 : 32'hA0 + 32'(i));
      check("b2b_src", 32'(wb_src), 32'(i));
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_hit", 32'(default_hit), i == 4 ? 32'd1 : 32'd0);
    end

    in_valid = 1'b0;
    tick();
    check("consume_valid", 32'(out_valid), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);

    in_valid = 1'b1; seletor = 3'd3; out_ready = 1'b0;
    tick();
    check("pre_rst_data", wb_data, 32'hA3);
    reset_n = 1'b0;
    tick();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", wb_data, 32'd0);
    reset_n = 1'b1; in_valid = 1'b0;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
